sym_word_packer: RTL and testbench
==================================

Name: sym_word_packer

Overview:
- Downstream consumer of the 2-bit sequential benchmark core outputs. Each cycle it samples the core's {O1,O0} pair as a 2-bit symbol.
- Packs four symbols into an 8-bit word and buffers words in a small FIFO with a valid/ready output.
- Keeps an overflow count and a count of 2'b11 symbols for trace capture and equivalence checking of the core.

Parameters:
- DEPTH, 4, FIFO depth in words; power of two, 2..16.
- CW, 8, width of the overflow counter and the symbol-11 counter; both counters saturate.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- sym_in  input  2  symbol; bit1 = core O1, bit0 = core O0.
- sym_vld  input  1  sym_in is valid this cycle.
- flush  input  1  push the partial word, zero-padded.
- word_data  output  8  FIFO head word.
- word_vld  output  1  FIFO not empty.
- word_rdy  input  1  consumer accepts the head word.
- fill  output  $clog2(DEPTH)+1  number of words stored.
- ovf  output  1  sticky; set when a word is dropped.
- ovf_cnt  output  CW  dropped-word count, saturating.
- cnt11  output  CW  count of accepted symbols equal to 2'b11, saturating.

Behaviour:
- Reset:
  - rst is sampled on the rising edge of clk and is synchronous, active-high; it overrides all other inputs.
  - Reset clears the pack register, slot counter (0..3), FIFO pointers, fill, ovf, ovf_cnt and cnt11.
  - Outputs after reset: word_vld=0, word_data=8'h00, fill=0, ovf=0, ovf_cnt=0, cnt11=0.
  - Asserting rst mid-word discards the partial word and all FIFO contents.
- Packing:
  - On sym_vld, sym_in is written to pack bits [2*slot+1 : 2*slot], so the first symbol lands in [1:0] and the fourth in [7:6]. The slot counter then increments.
  - When the fourth symbol is accepted (slot==3), the completed word {sym_in, pack[5:0]} is presented for push in the same cycle. slot wraps to 0 and the pack register clears.
- Flush:
  - With slot>0, the partial word is pushed with unused upper slots zero. slot returns to 0.
  - If sym_vld is also asserted, that symbol is included first. If it completes the word, exactly one push occurs.
  - With slot==0 and no completing symbol, flush has no effect.
- FIFO:
  - Push completes at the clock edge. A word completed in cycle t is visible at word_data/word_vld in cycle t+1 if the FIFO was empty.
  - Pop occurs in any cycle with word_vld && word_rdy. word_data then shows the next entry in the following cycle.
  - word_data holds its last value while empty.
- Full FIFO:
  - A push with fill==DEPTH and no simultaneous pop drops the word.
  - A drop sets ovf and increments ovf_cnt, saturating at 2^CW-1.
  - A push and pop in the same cycle with fill==DEPTH are both performed; nothing is dropped and fill is unchanged.
- Empty FIFO:
  - word_rdy with word_vld=0 has no effect.
  - A push into an empty FIFO does not bypass to the output in the same cycle.
- fill: +1 on push only, -1 on pop only, unchanged on both or neither. Pointers wrap modulo DEPTH.
- cnt11: increments on each accepted symbol equal to 2'b11, saturating at 2^CW-1. Flush padding is never counted.
- ovf: cleared only by rst.
- State machine, tracking the slot counter (IDLE is slot==0):
  - IDLE -> S1 -> S2 -> S3 -> IDLE, advancing on sym_vld.
  - flush from S1, S2 or S3 -> IDLE.

Test Plan:
- Basic pack: rst, then symbols 01,10,11,00 on consecutive cycles with word_rdy=0 -> the cycle after the 4th symbol: word_vld=1, word_data=8'h39, fill=1, cnt11=1.
- Flush: symbols 11,01 then flush -> word_data=8'h07, slot back to 0. A second flush with slot==0 leaves fill unchanged.
- Overflow: DEPTH=4, word_rdy=0, 5 full words of symbol 10 -> fill=4, all stored words 8'hAA, ovf=1, ovf_cnt=1. The 5th word is absent after draining.
- Full push+pop: fill=4, word_rdy=1 held while a 5th word completes -> no drop, ovf=0, fill stays 4, words drain in order.
- Saturation: CW=8, 300 symbols of 11 -> cnt11=255 and it stays 255.
- Reset mid-word: 2 symbols accepted, fill=2, then rst for one cycle -> all outputs zero next cycle. Next 4 symbols 00,00,00,01 -> word_data=8'h40.

Source files
------------

// File: rtl/sym_word_packer.sv
// sym_word_packer: packs 2-bit core symbols into bytes and queues them in a FIFO with overflow and symbol-11 counters
module sym_word_packer #(
  parameter int DEPTH = 4,
  parameter int CW = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               sym_in,
  input  logic                     sym_vld,
  input  logic                     flush,
  output logic [7:0]               word_data,
  output logic                     word_vld,
  input  logic                     word_rdy,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     ovf,
  output logic [CW-1:0]            ovf_cnt,
  output logic [CW-1:0]            cnt11
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  typedef enum logic [1:0] {IDLE, S1, S2, S3} state_t;
  state_t state, state_n;
  logic [1:0] slot;
  logic [7:0] pack, pack_n, word, head_n;
  logic push, pop, full, wr, drop, last;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  assign word_vld = fill != '0;
  always_comb begin
    slot = state;
    word = sym_vld ? pack | (8'(sym_in) << {slot, 1'b0}) : pack;
    push = (sym_vld && state == S3) || (flush && state != IDLE);
    state_n = push ? IDLE : sym_vld ? state_t'(slot + 2'd1) : state;
    pack_n = push ? 8'h00 : word;
    pop = word_vld && word_rdy;
    full = fill == FULL;
    wr = push && (!full || pop);
    drop = push && full && !pop;
    last = !word_vld || (pop && fill == ONE);
    head_n = last ? (wr ? word : word_data) : pop ? mem[rp + 1'b1] : mem[rp];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pack <= '0;
      wp <= '0;
      rp <= '0;
      fill <= '0;
      ovf <= 1'b0;
      ovf_cnt <= '0;
      cnt11 <= '0;
      word_data <= '0;
    end else begin
      state <= state_n;
      pack <= pack_n;
      if (wr) mem[wp] <= word;
      wp <= wr ? wp + 1'b1 : wp;
      rp <= pop ? rp + 1'b1 : rp;
      fill <= (wr && !pop) ? fill + ONE : (pop && !wr) ? fill - ONE : fill;
      word_data <= head_n;
      ovf <= ovf | drop;
      ovf_cnt <= (drop && ovf_cnt != '1) ? ovf_cnt + 1'b1 : ovf_cnt;
      cnt11 <= (sym_vld && sym_in == 2'b11 && cnt11 != '1) ? cnt11 + 1'b1 : cnt11;
    end
  end
endmodule

// File: tb/tb_sym_word_packer.sv
// tb_sym_word_packer: directed scoreboard bench for sym_word_packer
module tb_sym_word_packer;
  localparam int DEPTH = 4;
  localparam int CW = 8;
  logic clk = 0, rst = 0, sym_vld = 0, flush = 0, word_rdy = 0;
  logic [1:0] sym_in = 0;
  logic [7:0] word_data;
  logic word_vld, ovf;
  logic [$clog2(DEPTH):0] fill;
  logic [CW-1:0] ovf_cnt, cnt11;
  int checks = 0, errors = 0;
  logic [7:0] q[$];
  int slot_m = 0, ovf_cnt_m = 0, cnt11_m = 0;
  logic [7:0] pack_m = 0, last_m = 0;
  logic ovf_m = 0;
  sym_word_packer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .sym_in(sym_in), .sym_vld(sym_vld), .flush(flush),
    .word_data(word_data), .word_vld(word_vld), .word_rdy(word_rdy),
    .fill(fill), .ovf(ovf), .ovf_cnt(ovf_cnt), .cnt11(cnt11)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", n, got, exp);
    end
  endtask
  task automatic tick();
    logic [7:0] w;
    logic push;
    if (rst) begin
      q.delete();
      slot_m = 0; pack_m = 0; ovf_m = 0; ovf_cnt_m = 0; cnt11_m = 0; last_m = 0;
    end else begin
      if (word_rdy && q.size() > 0) begin
        chk("pop_vld", 32'(word_vld), 1);
        chk("pop_data", 32'(word_data), 32'(q[0]));
        last_m = q.pop_front();
      end
      w = pack_m;
      if (sym_vld) begin
        w[2*slot_m +: 2] = sym_in;
        if (sym_in == 2'b11 && cnt11_m < 255) cnt11_m++;
      end
      push = (sym_vld && slot_m == 3) || (flush && slot_m != 0);
      if (push) begin
        if (q.size() < DEPTH) q.push_back(w);
        else begin
          ovf_m = 1;
          if (ovf_cnt_m < 255) ovf_cnt_m++;
        end
      end
      slot_m = push ? 0 : sym_vld ? slot_m + 1 : slot_m;
      pack_m = push ? 8'h00 : w;
    end
    @(posedge clk);
    @(negedge clk);
    sym_vld = 0; flush = 0; rst = 0;
  endtask
  task automatic send(input logic [1:0] s);
    sym_in = s; sym_vld = 1;
    tick();
  endtask
  task automatic do_rst();
    rst = 1;
    tick();
  endtask
  task automatic state_chk(input string n);
    chk({n, "_fill"}, 32'(fill), q.size());
    chk({n, "_vld"}, 32'(word_vld), 32'(q.size() != 0));
    chk({n, "_data"}, 32'(word_data), 32'(q.size() != 0 ? q[0] : last_m));
    chk({n, "_ovf"}, 32'(ovf), 32'(ovf_m));
    chk({n, "_ovfcnt"}, 32'(ovf_cnt), ovf_cnt_m);
    chk({n, "_cnt11"}, 32'(cnt11), cnt11_m);
  endtask
  task automatic drain();
    word_rdy = 1;
    for (int i = 0; i < DEPTH + 2; i++) tick();
    word_rdy = 0;
  endtask
  initial begin
    @(negedge clk);
    do_rst();
    state_chk("reset");
    chk("reset_data0", 32'(word_data), 32'h00);
    send(2'b01); send(2'b10); send(2'b11);
    chk("partial_nvld", 32'(word_vld), 0);
    send(2'b00);
    state_chk("basic");
    chk("basic_39", 32'(word_data), 32'h39);
    chk("basic_cnt11", 32'(cnt11), 1);
    send(2'b11); send(2'b01);
    flush = 1;
    tick();
    state_chk("flush");
    chk("flush_fill2", 32'(fill), 2);
    flush = 1;
    tick();
    chk("flush_idle_fill", 32'(fill), 2);
    drain();
    state_chk("drain1");
    chk("hold_last_07", 32'(word_data), 32'h07);
    for (int i = 0; i < 20; i++) send(2'b10);
    state_chk("ovf");
    chk("ovf_fill4", 32'(fill), 4);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_cnt1", 32'(ovf_cnt), 1);
    drain();
    state_chk("ovf_drain");
    do_rst();
    for (int i = 0; i < 16; i++) send(2'b01);
    send(2'b00); send(2'b01); send(2'b10);
    word_rdy = 1;
    send(2'b11);
    word_rdy = 0;
    state_chk("fullpp");
    chk("fullpp_fill4", 32'(fill), 4);
    chk("fullpp_noovf", 32'(ovf), 0);
    drain();
    state_chk("fullpp_drain");
    do_rst();
    for (int i = 0; i < 10; i++) send(2'(i));
    chk("midrst_fill2", 32'(fill), 2);
    do_rst();
    state_chk("midrst");
    chk("midrst_zero", {word_data, 7'(fill), ovf, ovf_cnt, cnt11}, 0);
    send(2'b00); send(2'b00); send(2'b00); send(2'b01);
    state_chk("after_rst");
    chk("after_rst_40", 32'(word_data), 32'h40);
    do_rst();
    word_rdy = 1;
    for (int i = 0; i < 300; i++) send(2'b11);
    chk("sat_255", 32'(cnt11), 255);
    for (int i = 0; i < 4; i++) send(2'b11);
    state_chk("sat");
    chk("sat_hold", 32'(cnt11), 255);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
